// File: rtl/main_controller.sv
// Multi-cycle main control FSM: fetch, decode, execute, memory, writeback.
// Drives ALU class code, datapath selects, write enables and retire count.
module main_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [3:0]       alu_option,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       legal;
    logic [3:0] class_code;
    logic       retire;

    logic [3:0] alu_option_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic       addr_sel_c;
    logic       mem_req_c;
    logic       mem_we_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       reg_write_c;
    logic [1:0] wb_sel_c;
    logic       illegal_c;

    // Map the opcode to its ALU class code and flag unsupported opcodes.
    always_comb begin
        legal      = 1'b1;
        class_code = 4'b0000;
        case (opcode)
            OPC_LOAD:   class_code = 4'b0000;
            OPC_OPIMM:  class_code = 4'b0010;
            OPC_AUIPC:  class_code = 4'b0011;
            OPC_STORE:  class_code = 4'b0100;
            OPC_OP:     class_code = 4'b0110;
            OPC_LUI:    class_code = 4'b0111;
            OPC_BRANCH: class_code = 4'b1100;
            OPC_JAL:    class_code = 4'b0000;
            OPC_JALR:   class_code = 4'b0000;
            default:    legal      = 1'b0;
        endcase
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d         = S_FETCH;
        retire          = 1'b0;
        alu_option_c    = 4'b0000;
        alu_src_a_c     = 2'd0;
        alu_src_b_c     = 2'd0;
        addr_sel_c      = 1'b0;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        reg_write_c     = 1'b0;
        wb_sel_c        = 2'd0;
        illegal_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd2;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_option_c = class_code;
                case (opcode)
                    OPC_OP: begin
                        alu_src_a_c = 2'd1;
                        alu_src_b_c = 2'd0;
                        state_d     = S_WRITEBACK;
                    end
                    OPC_OPIMM: begin
                        alu_src_a_c = 2'd1;
                        alu_src_b_c = 2'd1;
                        state_d     = S_WRITEBACK;
                    end
                    OPC_LUI: begin
                        alu_src_a_c = 2'd2;
                        alu_src_b_c = 2'd1;
                        state_d     = S_WRITEBACK;
                    end
                    OPC_AUIPC: begin
                        alu_src_a_c = 2'd3;
                        alu_src_b_c = 2'd1;
                        state_d     = S_WRITEBACK;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_a_c = 2'd1;
                        alu_src_b_c = 2'd1;
                        state_d     = S_MEMORY;
                    end
                    OPC_BRANCH: begin
                        alu_src_a_c     = 2'd1;
                        alu_src_b_c     = 2'd0;
                        pc_write_cond_c = 1'b1;
                        retire          = 1'b1;
                    end
                    OPC_JAL: begin
                        alu_src_a_c = 2'd3;
                        alu_src_b_c = 2'd1;
                        pc_write_c  = 1'b1;
                        reg_write_c = 1'b1;
                        wb_sel_c    = 2'd2;
                        retire      = 1'b1;
                    end
                    OPC_JALR: begin
                        alu_src_a_c = 2'd1;
                        alu_src_b_c = 2'd1;
                        pc_write_c  = 1'b1;
                        reg_write_c = 1'b1;
                        wb_sel_c    = 2'd2;
                        retire      = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                alu_option_c = class_code;
                mem_req_c    = 1'b1;
                addr_sel_c   = 1'b1;
                mem_we_c     = (opcode == OPC_STORE);
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    state_d = S_MEMORY;
                end
            end
            S_WRITEBACK: begin
                alu_option_c = class_code;
                reg_write_c  = 1'b1;
                wb_sel_c     = (opcode == OPC_LOAD) ? 2'd1 : 2'd0;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset overrides every output so no request or write leaks out.
    always_comb begin
        alu_option    = reset ? 4'b0000 : alu_option_c;
        alu_src_a     = reset ? 2'd0    : alu_src_a_c;
        alu_src_b     = reset ? 2'd0    : alu_src_b_c;
        addr_sel      = reset ? 1'b0    : addr_sel_c;
        mem_req       = reset ? 1'b0    : mem_req_c;
        mem_we        = reset ? 1'b0    : mem_we_c;
        ir_write      = reset ? 1'b0    : ir_write_c;
        pc_write      = reset ? 1'b0    : pc_write_c;
        pc_write_cond = reset ? 1'b0    : pc_write_cond_c;
        reg_write     = reset ? 1'b0    : reg_write_c;
        wb_sel        = reset ? 2'd0    : wb_sel_c;
        illegal       = reset ? 1'b0    : illegal_c;
    end

    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    assign state     = state_q;
    assign instret   = instret_q;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule
